// File: rtl/cmpe125_lab6_tanveerkahlon.sv
// Vending controller: 25c item, accepts nickel/dime/quarter.
// Mealy FSM; credit held in PS, change returned with dispense.
module cmpe125_lab6_tanveerkahlon (
  input  logic       clk,
  input  logic       reset,
  input  logic       N,
  input  logic       D,
  input  logic       Q,
  output logic [2:0] PS,
  output logic [2:0] NS,
  output logic       W,
  output logic       X,
  output logic       Y,
  output logic       Z
);

  typedef enum logic [2:0] {
    S0  = 3'b000,
    S5  = 3'b001,
    S10 = 3'b010,
    S15 = 3'b011,
    S20 = 3'b100
  } state_t;

  logic [4:0] credit;
  logic [4:0] coin;
  logic [5:0] total;
  logic       bad_ps;
  logic       valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) PS <= S0;
    else        PS <= NS;
  end

  always_comb begin
    credit = 5'd0;
    bad_ps = 1'b0;
    unique case (PS)
      S0:      credit = 5'd0;
      S5:      credit = 5'd5;
      S10:     credit = 5'd10;
      S15:     credit = 5'd15;
      S20:     credit = 5'd20;
      default: bad_ps = 1'b1;
    endcase
  end

  // Multiple simultaneous coins are rejected as if none arrived.
  always_comb begin
    coin  = 5'd0;
    valid = 1'b0;
    unique case ({N, D, Q})
      3'b100:  begin coin = 5'd5;  valid = 1'b1; end
      3'b010:  begin coin = 5'd10; valid = 1'b1; end
      3'b001:  begin coin = 5'd25; valid = 1'b1; end
      default: begin coin = 5'd0;  valid = 1'b0; end
    endcase
  end

  assign total = {1'b0, credit} + {1'b0, coin};

  always_comb begin
    NS = PS;
    W  = 1'b0;
    X  = 1'b0;
    Y  = 1'b0;
    Z  = 1'b0;
    if (bad_ps) begin
      NS = S0;
    end else if (valid) begin
      unique case (total)
        6'd5:    NS = S5;
        6'd10:   NS = S10;
        6'd15:   NS = S15;
        6'd20:   NS = S20;
        6'd25:   begin NS = S0; W = 1'b1; end
        6'd30:   begin NS = S0; W = 1'b1; X = 1'b1; end
        6'd35:   begin NS = S0; W = 1'b1; Y = 1'b1; end
        6'd40:   begin NS = S0; W = 1'b1; X = 1'b1; Y = 1'b1; end
        6'd45:   begin NS = S0; W = 1'b1; Z = 1'b1; end
        default: NS = S0;
      endcase
    end
  end

endmodule

// File: tb/tb_cmpe125_lab6_tanveerkahlon.sv
// Bench for the vending controller: vector table plus reset sequences.
// Expected {PS,NS,W,X,Y,Z} queued on drive, popped when sampled.
module tb_cmpe125_lab6_tanveerkahlon;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       N = 1'b0;
  logic       D = 1'b0;
  logic       Q = 1'b0;
  logic [2:0] PS;
  logic [2:0] NS;
  logic       W, X, Y, Z;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] c;
    logic [2:0] ps;
    logic [2:0] ns;
    logic [3:0] o;
  } vec_t;

  vec_t       tbl[$];
  logic [9:0] sb[$];

  cmpe125_lab6_tanveerkahlon dut (
    .clk(clk), .reset(reset), .N(N), .D(D), .Q(Q),
    .PS(PS), .NS(NS), .W(W), .X(X), .Y(Y), .Z(Z)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic vec_t v(logic [2:0] c, logic [2:0] ps,
                             logic [2:0] ns, logic [3:0] o);
    vec_t r;
    r.c  = c;
    r.ps = ps;
    r.ns = ns;
    r.o  = o;
    return r;
  endfunction

  task automatic check(string name, logic [9:0] got, logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic pop_check(string name);
    logic [9:0] exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      exp = sb.pop_front();
      check(name, {PS, NS, W, X, Y, Z}, exp);
    end
  endtask

  task automatic apply(vec_t t, string name);
    @(posedge clk);
    #1;
    {N, D, Q} = t.c;
    sb.push_back({t.ps, t.ns, t.o});
    #3;
    pop_check(name);
  endtask

  initial begin
    // coin {N,D,Q}; outputs {W,X,Y,Z}
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(3'b100, 3'(i), (i == 4) ? 3'd0 : 3'(i + 1),
                      (i == 4) ? 4'b1000 : 4'b0000));
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(3'b100, 3'(i), 3'(i + 1), 4'b0000));
    tbl.push_back(v(3'b001, 3'd4, 3'd0, 4'b1001));
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(3'b100, 3'(i), 3'(i + 1), 4'b0000));
    tbl.push_back(v(3'b010, 3'd4, 3'd0, 4'b1100));
    tbl.push_back(v(3'b100, 3'd0, 3'd1, 4'b0000));
    tbl.push_back(v(3'b010, 3'd1, 3'd3, 4'b0000));
    tbl.push_back(v(3'b001, 3'd3, 3'd0, 4'b1110));
    tbl.push_back(v(3'b010, 3'd0, 3'd2, 4'b0000));
    tbl.push_back(v(3'b001, 3'd2, 3'd0, 4'b1010));
    tbl.push_back(v(3'b100, 3'd0, 3'd1, 4'b0000));
    tbl.push_back(v(3'b001, 3'd1, 3'd0, 4'b1100));
    tbl.push_back(v(3'b001, 3'd0, 3'd0, 4'b1000));
    tbl.push_back(v(3'b010, 3'd0, 3'd2, 4'b0000));
    tbl.push_back(v(3'b010, 3'd2, 3'd4, 4'b0000));
    tbl.push_back(v(3'b100, 3'd4, 3'd0, 4'b1000));
    tbl.push_back(v(3'b010, 3'd0, 3'd2, 4'b0000));
    tbl.push_back(v(3'b000, 3'd2, 3'd2, 4'b0000));
    tbl.push_back(v(3'b110, 3'd2, 3'd2, 4'b0000));
    tbl.push_back(v(3'b011, 3'd2, 3'd2, 4'b0000));
    tbl.push_back(v(3'b111, 3'd2, 3'd2, 4'b0000));
    tbl.push_back(v(3'b100, 3'd2, 3'd3, 4'b0000));

    // Reset held with a quarter present: state pinned, outputs follow S0.
    reset = 1'b0;
    Q = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #4;
      sb.push_back({3'd0, 3'd0, 4'b1000});
      pop_check("reset_hold_q");
    end
    Q = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    sb.push_back({3'd0, 3'd0, 4'b0000});
    pop_check("reset_release_idle");

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // Last vector left credit at S15; settle, then reset mid-cycle.
    @(posedge clk);
    #1;
    {N, D, Q} = 3'b000;
    #1;
    sb.push_back({3'd3, 3'd3, 4'b0000});
    pop_check("s15_idle");
    #1;
    reset = 1'b0;
    #1;
    sb.push_back({3'd0, 3'd0, 4'b0000});
    pop_check("async_reset_s15");
    #1;
    reset = 1'b1;

    apply(v(3'b000, 3'd0, 3'd0, 4'b0000), "after_reset_idle");
    apply(v(3'b100, 3'd0, 3'd1, 4'b0000), "s15b_n");
    apply(v(3'b010, 3'd1, 3'd3, 4'b0000), "s15b_d");
    apply(v(3'b010, 3'd3, 3'd0, 4'b1000), "s15_d_exact");
    apply(v(3'b000, 3'd0, 3'd0, 4'b0000), "final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
